board_io_top: RTL and testbench
===============================

Name: board_io_top

Overview:
- Top-level board wrapper that samples the 18 slide switches into an I/O register once per clock.
- Displays that register as eight hexadecimal digits on active-low seven-segment outputs.
- Mirrors the register on the red LEDs.
- Sits at the FPGA pin boundary. It is the future host of the CPU core, which later drives the same I/O register.

Parameters:
- SW_WIDTH, 18, number of switch inputs captured into the I/O register. Zero-extended to 32 bits for display.

Ports:
- CLOCK_50  in  1  system clock, rising-edge active.
- KEY  in  4  KEY[0] is the reset: asynchronous, active-high. KEY[3:1] unused.
- CLOCK2_50  in  1  unused.
- CLOCK3_50  in  1  unused.
- SW  in  18  slide switches.
- LEDG  out  9  green LEDs.
- LEDR  out  18  red LEDs.
- HEX0..HEX7  out  7 each  seven-segment digits, active-low, bit6=g … bit0=a.

Behaviour:
- Clocking and reset
  - Single clock domain, CLOCK_50.
  - KEY[0]=1 asynchronously clears io_reg (32 bits) to 0. Outputs update immediately, without waiting for a clock.
  - Reset release takes effect at the first rising edge with KEY[0]=0.
- Capture
  - Each rising edge out of reset: io_reg <= {14'b0, SW}.
  - Latency is 1 clock. A switch change becomes visible on HEX/LEDR after the next rising edge.
  - No debounce or synchronizer stages beyond this single register.
- Display
  - HEXn = seg(io_reg[4n+3:4n]), n=0..7. Purely combinational from io_reg.
  - HEX4 shows only SW[17:16]; its upper nibble bits are 0.
  - HEX5–HEX7 always show "0" while the value comes from SW.
- seg() encoding (active-low, gfedcba)
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- LEDs
  - LEDR = io_reg[17:0].
  - LEDG[0] = 1 when not in reset (KEY[0]=0), else 0.
  - LEDG[8:1] = 0.
- Reset values
  - io_reg = 0.
  - HEX0..HEX7 = 1000000.
  - LEDR = 0.
  - LEDG = 0.
- Boundary conditions
  - SW changing on the same edge as reset release: that edge's sampled value is captured.
  - Reset asserted mid-operation: all outputs return to reset values immediately.
  - X on unused inputs has no effect on any output.
- Outputs are glitch-free with respect to the clock: every HEX/LED output depends only on io_reg and KEY[0].

Test Plan:
1. Reset: KEY[0]=1 for 10 ns, SW=18'h3FFFF → all HEX = 1000000, LEDR=0, LEDG=0. Release KEY[0]=0; after 1 edge, HEX0–HEX3 = 0001110 ("F"), HEX4 = 0110000 ("3"), LEDG[0]=1.
2. Digit 0: SW=0x00001 → HEX0=1111001. Then SW=0x00008 → HEX0=0000000. Each checked one clock after the change.
3. Digits 1–2:
   - SW=0x00010 → HEX1=1111001.
   - SW=0x00080 → HEX1=0000000.
   - SW=0x00300 → HEX2=0110000.
   - SW=0x00100 → HEX2=1111001.
4. Digits 3–4:
   - SW=0x01000 → HEX3=1111001.
   - SW=0x04000 → HEX3=0011001.
   - SW=0x30000 → HEX4=0110000.
   - SW=0x20000 → HEX4=0100100.
   - HEX5–HEX7 stay 1000000 throughout.
5. Latency and full code sweep:
   - Change SW just after a rising edge → HEX and LEDR hold the old value until the next edge.
   - Sweep SW[3:0] through 0..F → HEX0 matches all 16 encodings.
   - SW=12345 (0x03039) → HEX0..HEX4 = 9,3,0,3,0 encodings; LEDR=0x03039.
6. Reset mid-run: with SW=0x03039 displayed, assert KEY[0]=1 between clock edges → outputs clear within the same time step, before any clock.

Source files
------------

// File: rtl/board_io_top.sv
// ----------------------------------------------------------------------------
// board_io_top
//
// Pin-level board wrapper. Samples the slide switches into a 32-bit I/O
// register once per clock and presents that register on the eight
// seven-segment digits (hexadecimal, active-low) and on the red LEDs.
// The I/O register is the hand-off point for the CPU core that will later
// be instantiated here and drive the same register.
//
// Ports:
//   CLOCK_50   in   1        system clock, rising edge active
//   CLOCK2_50  in   1        unused
//   CLOCK3_50  in   1        unused
//   KEY        in   4        KEY[0] = asynchronous active-high reset,
//                            KEY[3:1] unused
//   SW         in   SW_WIDTH slide switches
//   LEDG       out  9        LEDG[0] = running (not in reset), rest 0
//   LEDR       out  SW_WIDTH mirror of io_reg[SW_WIDTH-1:0]
//   HEX0..7    out  7 each   digit n shows io_reg[4n+3:4n], active-low
//                            segments, bit6=g .. bit0=a
// ----------------------------------------------------------------------------
module board_io_top #(
    parameter int SW_WIDTH = 18
) (
    input  logic                CLOCK_50,
    input  logic                CLOCK2_50,
    input  logic                CLOCK3_50,
    input  logic [3:0]          KEY,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [8:0]          LEDG,
    output logic [SW_WIDTH-1:0] LEDR,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);

    localparam int IO_WIDTH = 32;
    localparam int DIGITS   = 8;

    logic                clk;
    logic                rst;
    logic [IO_WIDTH-1:0] io_reg;
    logic [IO_WIDTH-1:0] sw_ext;
    logic [6:0]          digit_seg [DIGITS];

    assign clk = CLOCK_50;
    assign rst = KEY[0];

    // Inputs present on the board connector but not used by this design.
    // Folding them into a named sink keeps them visibly accounted for.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, CLOCK2_50, CLOCK3_50, KEY[3:1]};

    // Active-low seven-segment encoding, gfedcba.
    function automatic logic [6:0] seg(input logic [3:0] nibble);
        logic [6:0] code;
        code = 7'b1111111;
        unique case (nibble)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            4'hF: code = 7'b0001110;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    // Switches are zero-extended so the upper digits read "0".
    assign sw_ext = {{(IO_WIDTH-SW_WIDTH){1'b0}}, SW};

    // Single capture register; no synchronizer or debounce by design, the
    // display only needs a stable value per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_reg <= '0;
        end else begin
            io_reg <= sw_ext;
        end
    end

    always_comb begin
        for (int n = 0; n < DIGITS; n++) begin
            digit_seg[n] = seg(io_reg[4*n +: 4]);
        end
    end

    assign HEX0 = digit_seg[0];
    assign HEX1 = digit_seg[1];
    assign HEX2 = digit_seg[2];
    assign HEX3 = digit_seg[3];
    assign HEX4 = digit_seg[4];
    assign HEX5 = digit_seg[5];
    assign HEX6 = digit_seg[6];
    assign HEX7 = digit_seg[7];

    assign LEDR = io_reg[SW_WIDTH-1:0];

    // LEDG[0] follows the reset pin directly so it drops the instant the
    // reset key is pressed, together with the cleared io_reg.
    assign LEDG = {8'b0, ~rst};

endmodule

// File: tb/tb_board_io_top.sv
module tb_board_io_top;

   logic        clock_50;
   logic        clock2_50;
   logic        clock3_50;
   logic [3:0]  key;
   logic [17:0] sw;
   logic [8:0]  ledg;
   logic [17:0] ledr;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16];
   logic [6:0] hex_obs [8];

   board_io_top #(.SW_WIDTH(18)) dut (
      .CLOCK_50  (clock_50),
      .CLOCK2_50 (clock2_50),
      .CLOCK3_50 (clock3_50),
      .KEY       (key),
      .SW        (sw),
      .LEDG      (ledg),
      .LEDR      (ledr),
      .HEX0      (hex0),
      .HEX1      (hex1),
      .HEX2      (hex2),
      .HEX3      (hex3),
      .HEX4      (hex4),
      .HEX5      (hex5),
      .HEX6      (hex6),
      .HEX7      (hex7)
   );

   initial begin
      clock_50 = 1'b0;
      forever #10 clock_50 = ~clock_50;
   end

   always_comb begin
      hex_obs[0] = hex0;
      hex_obs[1] = hex1;
      hex_obs[2] = hex2;
      hex_obs[3] = hex3;
      hex_obs[4] = hex4;
      hex_obs[5] = hex5;
      hex_obs[6] = hex6;
      hex_obs[7] = hex7;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_display(input string tag, input logic [31:0] val);
      for (int n = 0; n < 8; n++) begin
         chk($sformatf("%s_hex%0d", tag, n), 32'(hex_obs[n]), 32'(seg_tab[val[4*n +: 4]]));
      end
      chk({tag, "_ledr"}, 32'(ledr), 32'(val[17:0]));
   endtask

   task automatic apply_sw(input logic [17:0] v);
      @(negedge clock_50);
      sw = v;
      @(posedge clock_50);
      #1;
   endtask

   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

      clock2_50 = 1'bx;
      clock3_50 = 1'bx;
      key       = {3'bxxx, 1'b1};
      sw        = 18'h3FFFF;

      // 1. Reset
      #5;
      check_display("reset", 32'h0);
      chk("reset_hex0_const", 32'(hex0), 32'(7'b1000000));
      chk("reset_ledg", 32'(ledg), 32'(9'h000));
      #10;
      check_display("reset_after_edge", 32'h0);
      @(negedge clock_50);
      key[0] = 1'b0;
      #1;
      chk("release_ledg_immediate", 32'(ledg), 32'(9'h001));
      chk("release_hex0_before_edge", 32'(hex0), 32'(7'b1000000));
      @(posedge clock_50);
      #1;
      chk("release_hex0", 32'(hex0), 32'(7'b0001110));
      chk("release_hex1", 32'(hex1), 32'(7'b0001110));
      chk("release_hex2", 32'(hex2), 32'(7'b0001110));
      chk("release_hex3", 32'(hex3), 32'(7'b0001110));
      chk("release_hex4", 32'(hex4), 32'(7'b0110000));
      chk("release_hex5", 32'(hex5), 32'(7'b1000000));
      chk("release_ledr", 32'(ledr), 32'(18'h3FFFF));
      chk("release_ledg", 32'(ledg), 32'(9'h001));

      // 2. Digit 0
      apply_sw(18'h00001);
      chk("d0_one", 32'(hex0), 32'(7'b1111001));
      apply_sw(18'h00008);
      chk("d0_eight", 32'(hex0), 32'(7'b0000000));

      // 3. Digits 1-2
      apply_sw(18'h00010);
      chk("d1_one", 32'(hex1), 32'(7'b1111001));
      apply_sw(18'h00080);
      chk("d1_eight", 32'(hex1), 32'(7'b0000000));
      apply_sw(18'h00300);
      chk("d2_three", 32'(hex2), 32'(7'b0110000));
      apply_sw(18'h00100);
      chk("d2_one", 32'(hex2), 32'(7'b1111001));

      // 4. Digits 3-4, upper digits stay "0"
      apply_sw(18'h01000);
      chk("d3_one", 32'(hex3), 32'(7'b1111001));
      apply_sw(18'h04000);
      chk("d3_four", 32'(hex3), 32'(7'b0011001));
      apply_sw(18'h30000);
      chk("d4_three", 32'(hex4), 32'(7'b0110000));
      chk("d4_hex5", 32'(hex5), 32'(7'b1000000));
      chk("d4_hex6", 32'(hex6), 32'(7'b1000000));
      chk("d4_hex7", 32'(hex7), 32'(7'b1000000));
      apply_sw(18'h20000);
      chk("d4_two", 32'(hex4), 32'(7'b0100100));
      check_display("d4_full", 32'h00020000);

      // 5. Latency
      sw = 18'h00005;
      #5;
      chk("lat_hold_hex0", 32'(hex0), 32'(7'b1000000));
      chk("lat_hold_hex4", 32'(hex4), 32'(7'b0100100));
      chk("lat_hold_ledr", 32'(ledr), 32'(18'h20000));
      @(posedge clock_50);
      #1;
      chk("lat_new_hex0", 32'(hex0), 32'(7'b0010010));
      chk("lat_new_ledr", 32'(ledr), 32'(18'h00005));

      for (int i = 0; i < 16; i++) begin
         apply_sw(18'(i));
         check_display($sformatf("sweep_%0d", i), 32'(i));
      end

      apply_sw(18'h03039);
      chk("n12345_hex0", 32'(hex0), 32'(7'b0010000));
      chk("n12345_hex1", 32'(hex1), 32'(7'b0110000));
      chk("n12345_hex2", 32'(hex2), 32'(7'b1000000));
      chk("n12345_hex3", 32'(hex3), 32'(7'b0110000));
      chk("n12345_hex4", 32'(hex4), 32'(7'b1000000));
      chk("n12345_ledr", 32'(ledr), 32'(18'h03039));

      // 6. Reset mid-run
      #4;
      key[0] = 1'b1;
      #1;
      check_display("midrst", 32'h0);
      chk("midrst_ledg", 32'(ledg), 32'(9'h000));
      @(posedge clock_50);
      #1;
      check_display("midrst_held", 32'h0);

      @(negedge clock_50);
      key[0] = 1'b0;
      sw     = 18'h2ABCD;
      @(posedge clock_50);
      #1;
      check_display("release_capture", 32'h0002ABCD);
      chk("release_capture_ledg", 32'(ledg), 32'(9'h001));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
